// File: rtl/drv_ad56x3_cfg_master.sv
// Avalon-MM master that writes the AD56x3 driver parameter map (optional soft reset, then adr 1..5)
// and can read adr 1..5 back to compare against the values written.
module drv_ad56x3_cfg_master #(
   parameter int RD_LATENCY = 1,
   parameter bit SOFT_RST   = 1'b1,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        verify,
   input  logic        cfgGenSel,
   input  logic        cfgChSwap,
   input  logic [15:0] cfgCeDiv,
   input  logic [15:0] cfgIncr0,
   input  logic [15:0] cfgIncr1,
   output logic        busy,
   output logic        done,
   output logic [1:0]  errCode,
   output logic [2:0]  errAdr,
   output logic [2:0]  avmAdr,
   output logic        avmWr,
   output logic [15:0] avmWrData,
   output logic        avmRd,
   input  logic [15:0] avmRdData,
   input  logic        avmWaitReq
);

   typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, FIN} state_t;

   localparam logic [2:0]  FIRST_ADR = SOFT_RST ? 3'd0 : 3'd1;
   localparam logic [2:0]  LAT_END   = 3'(RD_LATENCY);
   localparam logic [15:0] STALL_END = 16'(TIMEOUT - 1);

   state_t      state, state_next;
   logic [2:0]  adr, adr_next;
   logic [15:0] stall_cnt, stall_next;
   logic [2:0]  lat_cnt, lat_next;
   logic [1:0]  err_code, err_code_next;
   logic [2:0]  err_adr, err_adr_next;
   logic        gen_sel, ch_swap, verify_q;
   logic [15:0] ce_div, incr0, incr1;
   logic [15:0] reg_value;

   // Value that belongs at the current address; used both as write data and as readback reference.
   always_comb begin
      reg_value = 16'h0000;
      case (adr)
         3'd0:    reg_value = 16'h0001;
         3'd1:    reg_value = {15'b0, gen_sel};
         3'd2:    reg_value = {15'b0, ch_swap};
         3'd3:    reg_value = ce_div;
         3'd4:    reg_value = incr0;
         3'd5:    reg_value = incr1;
         default: reg_value = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         adr       <= 3'd0;
         stall_cnt <= 16'd0;
         lat_cnt   <= 3'd0;
         err_code  <= 2'd0;
         err_adr   <= 3'd0;
         gen_sel   <= 1'b0;
         ch_swap   <= 1'b0;
         verify_q  <= 1'b0;
         ce_div    <= 16'd0;
         incr0     <= 16'd0;
         incr1     <= 16'd0;
      end else begin
         state     <= state_next;
         adr       <= adr_next;
         stall_cnt <= stall_next;
         lat_cnt   <= lat_next;
         err_code  <= err_code_next;
         err_adr   <= err_adr_next;
         // Shadow copies keep the sequence immune to cfg changes while busy.
         if (state == IDLE && start) begin
            gen_sel  <= cfgGenSel;
            ch_swap  <= cfgChSwap;
            verify_q <= verify;
            ce_div   <= cfgCeDiv;
            incr0    <= cfgIncr0;
            incr1    <= cfgIncr1;
         end
      end
   end

   always_comb begin
      state_next    = state;
      adr_next      = adr;
      stall_next    = stall_cnt;
      lat_next      = lat_cnt;
      err_code_next = err_code;
      err_adr_next  = err_adr;
      avmWr         = 1'b0;
      avmRd         = 1'b0;
      avmAdr        = 3'd0;
      avmWrData     = 16'h0000;
      busy          = 1'b1;
      done          = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next    = WR;
               adr_next      = FIRST_ADR;
               stall_next    = 16'd0;
               err_code_next = 2'd0;
               err_adr_next  = 3'd0;
            end
         end
         WR: begin
            avmWr     = 1'b1;
            avmAdr    = adr;
            avmWrData = reg_value;
            if (!avmWaitReq) begin
               stall_next = 16'd0;
               if (adr == 3'd5) begin
                  if (verify_q) begin
                     state_next = RD;
                     adr_next   = 3'd1;
                  end else begin
                     state_next = FIN;
                  end
               end else begin
                  adr_next = adr + 3'd1;
               end
            end else if (stall_cnt == STALL_END) begin
               state_next    = FIN;
               err_code_next = 2'd2;
               err_adr_next  = adr;
               stall_next    = 16'd0;
            end else begin
               stall_next = stall_cnt + 16'd1;
            end
         end
         RD: begin
            avmRd  = 1'b1;
            avmAdr = adr;
            if (!avmWaitReq) begin
               stall_next = 16'd0;
               lat_next   = 3'd1;
               state_next = RD_WAIT;
            end else if (stall_cnt == STALL_END) begin
               state_next    = FIN;
               err_code_next = 2'd2;
               err_adr_next  = adr;
               stall_next    = 16'd0;
            end else begin
               stall_next = stall_cnt + 16'd1;
            end
         end
         RD_WAIT: begin
            avmAdr = adr;
            // lat_cnt is the number of cycles elapsed since the read accept edge.
            if (lat_cnt == LAT_END) begin
               if (avmRdData != reg_value) begin
                  state_next    = FIN;
                  err_code_next = 2'd1;
                  err_adr_next  = adr;
               end else if (adr == 3'd5) begin
                  state_next = FIN;
               end else begin
                  state_next = RD;
                  adr_next   = adr + 3'd1;
               end
            end else begin
               lat_next = lat_cnt + 3'd1;
            end
         end
         FIN: begin
            avmAdr     = adr;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign errCode = err_code;
   assign errAdr  = err_adr;

endmodule

// File: tb/tb_drv_ad56x3_cfg_master.sv
// Bench for drv_ad56x3_cfg_master: a stalling slave model logs every accepted transfer and a
// transaction-level model predicts the transfer list, timing, and error result of each sequence.
module tb_drv_ad56x3_cfg_master;

   localparam int LAT  = 1;
   localparam bit SOFT = 1'b1;
   localparam int TMO  = 4;

   typedef struct {
      bit          is_wr;
      logic [2:0]  adr;
      logic [15:0] data;
      int          rel;
   } bus_event_t;

   logic        clk = 1'b0;
   logic        reset, start, verify, cfgGenSel, cfgChSwap;
   logic [15:0] cfgCeDiv, cfgIncr0, cfgIncr1;
   logic        busy, done, avmWr, avmRd;
   logic [1:0]  errCode;
   logic [2:0]  errAdr, avmAdr;
   logic [15:0] avmWrData;
   logic [15:0] avmRdData  = 16'h0000;
   logic        avmWaitReq = 1'b0;

   int          check_count = 0;
   int          pass_count  = 0;
   int          cyc = 0;
   int          seq_start = 0;
   bus_event_t  ev_log[$];
   bus_event_t  exp_log[$];
   int          done_log[$];
   logic [1:0]  cap_err;
   logic [2:0]  cap_eadr;
   logic        cap_busy;
   int          stall_for[8];
   int          stall_used = 0;
   logic [15:0] mem[8];
   logic [15:0] rd_pipe[LAT+1];
   logic [2:0]  ovr_adr = 3'd0;
   logic [15:0] ovr_val = 16'h0000;
   logic [4:0]  prev_req = 5'd0;
   logic        prev_stalled = 1'b0;
   logic [20:0] prev_full = 21'd0;

   drv_ad56x3_cfg_master #(.RD_LATENCY(LAT), .SOFT_RST(SOFT), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .verify(verify),
      .cfgGenSel(cfgGenSel), .cfgChSwap(cfgChSwap), .cfgCeDiv(cfgCeDiv),
      .cfgIncr0(cfgIncr0), .cfgIncr1(cfgIncr1),
      .busy(busy), .done(done), .errCode(errCode), .errAdr(errAdr),
      .avmAdr(avmAdr), .avmWr(avmWr), .avmWrData(avmWrData), .avmRd(avmRd),
      .avmRdData(avmRdData), .avmWaitReq(avmWaitReq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_count++;
      if (obs === exp) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] reg_val(input int a, input logic g, input logic c,
                                           input logic [15:0] d, input logic [15:0] i0,
                                           input logic [15:0] i1);
      case (a)
         0:       return 16'h0001;
         1:       return {15'b0, g};
         2:       return {15'b0, c};
         3:       return d;
         4:       return i0;
         5:       return i1;
         default: return 16'h0000;
      endcase
   endfunction

   // Slave model: decides stalls, logs accepted transfers, and delivers read data LAT edges after accept.
   always @(negedge clk) begin
      bus_event_t ev;
      logic [4:0] req;
      req = {avmWr, avmRd, avmAdr};
      if (req != prev_req) stall_used = 0;
      if ((avmWr || avmRd) && stall_used < stall_for[avmAdr]) begin
         avmWaitReq = 1'b1;
         stall_used++;
      end else begin
         avmWaitReq = 1'b0;
      end
      for (int i = LAT; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = 16'($urandom);
      if ((avmWr || avmRd) && !avmWaitReq) begin
         ev.is_wr = avmWr;
         ev.adr   = avmAdr;
         ev.data  = avmWr ? avmWrData : 16'h0000;
         ev.rel   = cyc - seq_start + 1;
         ev_log.push_back(ev);
         if (avmWr) mem[avmAdr] = avmWrData;
         else rd_pipe[0] = (avmAdr == ovr_adr) ? ovr_val : mem[avmAdr];
      end
      avmRdData = rd_pipe[LAT];
      if (done) begin
         done_log.push_back(cyc - seq_start + 1);
         cap_err  = errCode;
         cap_eadr = errAdr;
         cap_busy = busy;
      end
      checkOutput("wr_rd_excl", {63'b0, avmWr & avmRd}, 64'd0);
      if (!busy) checkOutput("idle_adr", {61'b0, avmAdr}, 64'd0);
      if (prev_stalled && (avmWr || avmRd))
         checkOutput("stall_hold", {43'b0, avmWr, avmRd, avmAdr, avmWrData}, {43'b0, prev_full});
      prev_stalled = (avmWr || avmRd) && avmWaitReq;
      prev_full    = {avmWr, avmRd, avmAdr, avmWrData};
      prev_req     = req;
   end

   task automatic applyStimulus(input logic v, input logic g, input logic c, input logic [15:0] d,
                                input logic [15:0] i0, input logic [15:0] i1,
                                input bit busy_start, input bit fin_start, output int done_rel);
      int         t, n, first, exp_done, last;
      logic [1:0] exp_err;
      logic [2:0] exp_eadr;
      logic [15:0] rv;
      bit         stop;
      bus_event_t e;
      // Transaction-level prediction: each request costs its stall cycles plus one, reads add LAT.
      exp_log.delete();
      t = 0; exp_err = 2'd0; exp_eadr = 3'd0; stop = 0;
      first = SOFT ? 0 : 1;
      for (int a = first; a <= 5 && !stop; a++) begin
         if (stall_for[a] >= TMO) begin
            t += TMO; exp_err = 2'd2; exp_eadr = 3'(a); stop = 1;
         end else begin
            t += stall_for[a] + 1;
            e.is_wr = 1'b1; e.adr = 3'(a); e.data = reg_val(a, g, c, d, i0, i1); e.rel = t;
            exp_log.push_back(e);
         end
      end
      for (int a = 1; v && a <= 5 && !stop; a++) begin
         if (stall_for[a] >= TMO) begin
            t += TMO; exp_err = 2'd2; exp_eadr = 3'(a); stop = 1;
         end else begin
            t += stall_for[a] + 1;
            e.is_wr = 1'b0; e.adr = 3'(a); e.data = 16'h0000; e.rel = t;
            exp_log.push_back(e);
            t += LAT;
            rv = (3'(a) == ovr_adr) ? ovr_val : reg_val(a, g, c, d, i0, i1);
            if (rv != reg_val(a, g, c, d, i0, i1)) begin
               exp_err = 2'd1; exp_eadr = 3'(a); stop = 1;
            end
         end
      end
      exp_done = t + 1;

      @(negedge clk); #1;
      ev_log.delete(); done_log.delete();
      cfgGenSel = g; cfgChSwap = c; cfgCeDiv = d; cfgIncr0 = i0; cfgIncr1 = i1; verify = v;
      start = 1'b1;
      seq_start = cyc + 1;
      @(negedge clk); #1;
      start = 1'b0;
      cfgGenSel = 1'($urandom); cfgChSwap = 1'($urandom); cfgCeDiv = 16'($urandom);
      cfgIncr0 = 16'($urandom); cfgIncr1 = 16'($urandom); verify = 1'($urandom);
      n = 0;
      while (done_log.size() == 0 && n < 300) begin
         start = busy_start && (n == 2);
         @(negedge clk); #1;
         n++;
      end
      start = 1'b0;
      checkOutput("done_seen", 64'(done_log.size()), 64'd1);
      if (fin_start && done_log.size() > 0) begin
         start = 1'b1;
         @(negedge clk); #1;
         start = 1'b0;
      end
      repeat (5) @(negedge clk);
      #1;
      checkOutput("done_count", 64'(done_log.size()), 64'd1);
      done_rel = (done_log.size() > 0) ? done_log[0] : -1;
      checkOutput("done_cycle", 64'(done_rel), 64'(exp_done));
      checkOutput("ev_count", 64'(ev_log.size()), 64'(exp_log.size()));
      last = (ev_log.size() < exp_log.size()) ? ev_log.size() : exp_log.size();
      for (int i = 0; i < last; i++) begin
         checkOutput($sformatf("ev%0d_kind", i), {63'b0, ev_log[i].is_wr}, {63'b0, exp_log[i].is_wr});
         checkOutput($sformatf("ev%0d_adr", i), {61'b0, ev_log[i].adr}, {61'b0, exp_log[i].adr});
         checkOutput($sformatf("ev%0d_data", i), {48'b0, ev_log[i].data}, {48'b0, exp_log[i].data});
         checkOutput($sformatf("ev%0d_cycle", i), 64'(ev_log[i].rel), 64'(exp_log[i].rel));
      end
      if (done_log.size() > 0) begin
         checkOutput("err_at_done", {62'b0, cap_err}, {62'b0, exp_err});
         checkOutput("eadr_at_done", {61'b0, cap_eadr}, {61'b0, exp_eadr});
         checkOutput("busy_at_done", {63'b0, cap_busy}, 64'd1);
      end
      checkOutput("err_held", {62'b0, errCode}, {62'b0, exp_err});
      checkOutput("eadr_held", {61'b0, errAdr}, {61'b0, exp_eadr});
      checkOutput("busy_after", {63'b0, busy}, 64'd0);
   endtask

   task automatic clearStalls();
      for (int i = 0; i < 8; i++) stall_for[i] = 0;
   endtask

   initial begin
      int d_rel, n;
      reset = 1'b1; start = 1'b0; verify = 1'b0;
      cfgGenSel = 1'b0; cfgChSwap = 1'b0; cfgCeDiv = 16'd0; cfgIncr0 = 16'd0; cfgIncr1 = 16'd0;
      clearStalls();
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
      for (int i = 0; i <= LAT; i++) rd_pipe[i] = 16'h0000;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_state", {36'b0, busy, done, avmWr, avmRd, avmAdr, avmWrData, errCode, errAdr},
                  64'd0);
      reset = 1'b0;

      $display("[TB] directed: write-only sequence");
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd200, 16'h0003, 16'hFFFE, 0, 0, d_rel);
      checkOutput("t1_done_cycle", 64'(d_rel), 64'd7);

      $display("[TB] directed: write plus readback");
      applyStimulus(1'b1, 1'b1, 1'b0, 16'd200, 16'h0003, 16'hFFFE, 0, 0, d_rel);
      checkOutput("t2_done_cycle", 64'(d_rel), 64'd17);

      $display("[TB] directed: readback mismatch on adr 3");
      ovr_adr = 3'd3; ovr_val = 16'h007D;
      applyStimulus(1'b1, 1'b1, 1'b0, 16'd200, 16'h0003, 16'hFFFE, 0, 0, d_rel);
      checkOutput("t3_err", {62'b0, errCode}, 64'd1);
      checkOutput("t3_eadr", {61'b0, errAdr}, 64'd3);
      ovr_adr = 3'd0;

      $display("[TB] directed: 3-cycle stall on adr 2 write");
      stall_for[2] = 3;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd200, 16'h0003, 16'hFFFE, 0, 0, d_rel);
      checkOutput("t4_done_cycle", 64'(d_rel), 64'd10);
      clearStalls();

      $display("[TB] directed: waitrequest stuck on adr 1");
      stall_for[1] = 1000;
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0005, 16'h0006, 0, 0, d_rel);
      checkOutput("t5_err", {62'b0, errCode}, 64'd2);
      checkOutput("t5_eadr", {61'b0, errAdr}, 64'd1);
      clearStalls();

      $display("[TB] directed: start while busy and in the done cycle");
      applyStimulus(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h8000, 16'h7FFF, 1, 1, d_rel);

      $display("[TB] directed: reset during adr 3 write");
      @(negedge clk); #1;
      cfgGenSel = 1'b1; cfgChSwap = 1'b1; cfgCeDiv = 16'h0ABC; cfgIncr0 = 16'h0011; cfgIncr1 = 16'h0022;
      verify = 1'b1; start = 1'b1; seq_start = cyc + 1;
      @(negedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(avmWr && avmAdr == 3'd3) && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      checkOutput("rst_reached_adr3", {63'b0, avmWr && avmAdr == 3'd3}, 64'd1);
      reset = 1'b1;
      @(negedge clk); #1;
      checkOutput("rst_mid_outputs", {36'b0, busy, done, avmWr, avmRd, avmAdr, avmWrData, errCode, errAdr},
                  64'd0);
      reset = 1'b0;
      ev_log.delete(); done_log.delete();
      repeat (8) @(negedge clk);
      #1;
      checkOutput("rst_no_done", 64'(done_log.size()), 64'd0);
      checkOutput("rst_no_bus", 64'(ev_log.size()), 64'd0);
      checkOutput("rst_idle", {63'b0, busy}, 64'd0);

      $display("[TB] randomized sequences");
      for (int k = 0; k < 30; k++) begin
         logic [15:0] rd, r0, r1;
         bit          calm;
         calm = ($urandom_range(0, 1) == 0);
         for (int a = 0; a < 8; a++) begin
            if (calm) stall_for[a] = 0;
            else if ($urandom_range(0, 19) == 0) stall_for[a] = TMO + $urandom_range(0, 3);
            else stall_for[a] = $urandom_range(0, 2);
         end
         if ($urandom_range(0, 3) == 0) begin
            ovr_adr = 3'($urandom_range(1, 5));
            ovr_val = 16'($urandom);
         end else begin
            ovr_adr = 3'd0;
         end
         rd = 16'($urandom); r0 = 16'($urandom); r1 = 16'($urandom);
         applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), rd, r0, r1,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, d_rel);
      end

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
